// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
//   state_t : sequencer FSM states
//   tag_t   : per-term tag travelling alongside the DSP pipeline
//   OPM_*   : DSP48A1 OPMODE encodings used by the sequencer
//   DSP_LAT : cycles from operand register to P (A1/B1 -> M -> P)
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  localparam logic [7:0] OPM_FIRST = 8'h0D;  // X=M, Z=C
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P
  localparam logic [7:0] OPM_IDLE  = 8'h00;

  localparam int unsigned DSP_LAT = 3;

endpackage

// File: rtl/dsp_mac_seq_tag_pipe.sv
// mac_tag_pipe: DSP_LAT-stage shift register of term tags that tracks
// each operand pair through the DSP slice registers.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear of every stage
//   i_tag   : tag entering stage 0
//   o_tags  : all stages, index 0 newest, DSP_LAT-1 oldest
module mac_tag_pipe
  import dsp_mac_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  tag_t                 i_tag,
  output tag_t [DSP_LAT-1:0]   o_tags
);

  tag_t [DSP_LAT-1:0] r_tags;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tags <= '0;
    end else if (i_clr) begin
      r_tags <= '0;
    end else begin
      r_tags <= {r_tags[DSP_LAT-2:0], i_tag};
    end
  end

  assign o_tags = r_tags;

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequences a stream of unsigned 18-bit operand pairs into an
// external DSP48A1 (A1/B1/C/M/P registered, OPMODE unregistered) so that LEN
// products accumulate onto cfg_bias, then presents the 48-bit dot product.
//   CLK, RST_N           : clock, asynchronous active-low reset
//   clr                  : synchronous abort of the current dot product
//   cfg_bias             : bias loaded through C with the first term
//   in_valid/in_ready    : operand pair handshake (in_a, in_b)
//   out_valid/out_ready  : result handshake (out_data)
//   dsp_a/b/c/d          : DSP data inputs (dsp_d tied to zero)
//   dsp_opmode, dsp_ce   : DSP control
//   dsp_p                : DSP accumulator output
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic [47:0] cfg_bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [17:0] dsp_d,
  output logic [47:0] dsp_c,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_ce,
  input  logic [47:0] dsp_p
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_live;
  logic [17:0]        r_a;
  logic [17:0]        r_b;
  logic [47:0]        r_c;
  logic [47:0]        r_out;
  tag_t               w_push;
  tag_t [DSP_LAT-1:0] w_tags;
  tag_t               w_tag_op;
  logic               w_hs;
  logic               w_last;
  logic               w_empty;
  logic               w_drained;
  logic [7:0]         w_opmode;

  // r_live holds in_ready and CE low until the first edge after reset.
  assign in_ready = r_live && ((r_state == IDLE) || (r_state == ACCUM));
  assign w_hs     = in_valid && in_ready && !clr;

  always_comb begin
    w_last = 1'b0;
    if (r_state == IDLE) begin
      w_last = (LEN == 1);
    end else begin
      w_last = (r_cnt == CNT_W'(LEN - 1));
    end
    w_push       = '0;
    w_push.v     = w_hs;
    w_push.first = w_hs && (r_state == IDLE);
    w_push.last  = w_hs && w_last;
  end

  mac_tag_pipe u_tag_pipe (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (clr),
    .i_tag   (w_push),
    .o_tags  (w_tags)
  );

  // Tags carry no bits unless v is set, so an all-zero pipe is empty.
  assign w_empty  = (w_tags == '0);
  assign w_tag_op = w_tags[DSP_LAT-1];

  // P is stable once the last term's tag has shifted out of the pipe.
  always_comb begin
    w_drained = 1'b1;
    for (int unsigned i = 0; i < DSP_LAT; i++) begin
      if (w_tags[i].last) begin
        w_drained = 1'b0;
      end
    end
  end

  always_comb begin
    w_opmode = OPM_HOLD;
    if (w_tag_op.v) begin
      w_opmode = w_tag_op.first ? OPM_FIRST : OPM_ACC;
    end else if ((r_state == IDLE) && w_empty) begin
      w_opmode = OPM_IDLE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = (LEN == 1) ? DRAIN : ACCUM;
      ACCUM:   if (w_hs && w_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_drained) w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (clr) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_out   <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      r_a     <= w_hs ? in_a : '0;
      r_b     <= w_hs ? in_b : '0;
      if (clr) begin
        r_cnt <= '0;
      end else if (w_hs) begin
        r_cnt <= (r_state == IDLE) ? CNT_W'(1) : r_cnt + 1'b1;
      end
      if (w_hs && (r_state == IDLE)) begin
        r_c <= cfg_bias;
      end
      if (!clr && (r_state == DRAIN) && w_drained) begin
        r_out <= dsp_p;
      end
    end
  end

  assign out_valid  = (r_state == OUT);
  assign out_data   = r_out;
  assign dsp_a      = r_a;
  assign dsp_b      = r_b;
  assign dsp_d      = '0;
  assign dsp_c      = r_c;
  assign dsp_opmode = w_opmode;
  assign dsp_ce     = r_live;

endmodule

// File: tb/tb_dsp_mac_seq.sv
module tb_dsp_mac_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        clr = 1'b0;
  logic [47:0] cfg_bias = '0;
  logic [17:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        out_ready0 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, dsp_ce0, dsp_ce1;
  logic [47:0] out_data0, out_data1, dsp_c0, dsp_c1, dsp_p0, dsp_p1;
  logic [17:0] dsp_a0, dsp_b0, dsp_d0, dsp_a1, dsp_b1, dsp_d1;
  logic [7:0]  dsp_opmode0, dsp_opmode1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int hs_cyc   = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dsp_mac_seq #(.LEN(4)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .clr(clr), .cfg_bias(cfg_bias),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .dsp_a(dsp_a0), .dsp_b(dsp_b0), .dsp_d(dsp_d0), .dsp_c(dsp_c0),
    .dsp_opmode(dsp_opmode0), .dsp_ce(dsp_ce0), .dsp_p(dsp_p0)
  );

  dsp_mac_seq #(.LEN(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .clr(clr), .cfg_bias(cfg_bias),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .dsp_a(dsp_a1), .dsp_b(dsp_b1), .dsp_d(dsp_d1), .dsp_c(dsp_c1),
    .dsp_opmode(dsp_opmode1), .dsp_ce(dsp_ce1), .dsp_p(dsp_p1)
  );

  // DSP48A1 behavioural slice: A1/B1, C, M, P registered; OPMODE direct.
  function automatic logic [47:0] p_next(input logic [7:0] opm, input logic [35:0] m,
                                         input logic [47:0] c, input logic [47:0] p);
    logic [47:0] x, z;
    x = (opm[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
    case (opm[3:2])
      2'b10:   z = p;
      2'b11:   z = c;
      default: z = '0;
    endcase
    return opm[7] ? (z - x) : (z + x);
  endfunction

  logic [17:0] a1_0, b1_0, a1_1, b1_1;
  logic [35:0] m_0, m_1;
  logic [47:0] c_0, c_1, p_0, p_1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a1_0 <= '0; b1_0 <= '0; m_0 <= '0; c_0 <= '0; p_0 <= '0;
    end else if (dsp_ce0) begin
      a1_0 <= dsp_a0; b1_0 <= dsp_b0; m_0 <= a1_0 * b1_0; c_0 <= dsp_c0;
      p_0  <= p_next(dsp_opmode0, m_0, c_0, p_0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a1_1 <= '0; b1_1 <= '0; m_1 <= '0; c_1 <= '0; p_1 <= '0;
    end else if (dsp_ce1) begin
      a1_1 <= dsp_a1; b1_1 <= dsp_b1; m_1 <= a1_1 * b1_1; c_1 <= dsp_c1;
      p_1  <= p_next(dsp_opmode1, m_1, c_1, p_1);
    end
  end

  assign dsp_p0 = p_0;
  assign dsp_p1 = p_1;

  // Opmode trace of dut0 from the first-term opmode until the result appears.
  logic       mon_en = 1'b0;
  logic       seen;
  logic [7:0] opq[$];

  always @(negedge CLK) begin
    if (!mon_en) begin
      seen <= 1'b0;
      opq.delete();
    end else if (!out_valid0 && (seen || dsp_opmode0 == 8'h0D)) begin
      seen <= 1'b1;
      opq.push_back(dsp_opmode0);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input logic sel);
    return sel ? in_ready1 : in_ready0;
  endfunction

  function automatic logic ov(input logic sel);
    return sel ? out_valid1 : out_valid0;
  endfunction

  task automatic push(input logic sel, input logic [17:0] a, input logic [17:0] b);
    int n;
    n = 0;
    @(negedge CLK);
    in_a = a;
    in_b = b;
    if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    while (!rdy(sel) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!rdy(sel)) check("push_timeout", 64'(rdy(sel)), 64'd1);
    @(posedge CLK);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic wait_result(input logic sel, input string tag, input logic [47:0] exp);
    int n;
    n = 0;
    while (!ov(sel) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!ov(sel)) check({tag, "_timeout"}, 64'(ov(sel)), 64'd1);
    check({tag, "_lat"}, 64'(cyc - hs_cyc), 64'd4);
    check({tag, "_data"}, 64'(sel ? out_data1 : out_data0), 64'(exp));
  endtask

  task automatic take(input logic sel, input string tag);
    @(negedge CLK);
    if (sel) out_ready1 = 1'b1; else out_ready0 = 1'b1;
    @(posedge CLK);
    #1;
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;
    check({tag, "_ovdrop"}, 64'(ov(sel)), 64'd0);
    check({tag, "_rdy_idle"}, 64'(rdy(sel)), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready0), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid0), 64'd0);
    check({tag, "_out_data"}, 64'(out_data0), 64'd0);
    check({tag, "_dsp_a"}, 64'(dsp_a0), 64'd0);
    check({tag, "_dsp_b"}, 64'(dsp_b0), 64'd0);
    check({tag, "_dsp_c"}, 64'(dsp_c0), 64'd0);
    check({tag, "_opmode"}, 64'(dsp_opmode0), 64'd0);
    check({tag, "_ce"}, 64'(dsp_ce0), 64'd0);
  endtask

  task automatic dot_std(input string tag);
    logic [17:0] av[4];
    logic [17:0] bv[4];
    av = '{18'd1, 18'd2, 18'd3, 18'd4};
    bv = '{18'd5, 18'd6, 18'd7, 18'd8};
    cfg_bias = 48'd100;
    for (int i = 0; i < 4; i++) push(1'b0, av[i], bv[i]);
    wait_result(1'b0, tag, 48'd170);
  endtask

  initial begin
    int bad;
    int n08;

    // Reset state
    #12;
    check_reset_vals("rst");
    check("rst_dsp_d", 64'(dsp_d0), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("rel_in_ready", 64'(in_ready0), 64'd1);
    check("rel_ce", 64'(dsp_ce0), 64'd1);

    // Back-to-back dot product: 100 + 5 + 12 + 21 + 32 = 170
    mon_en = 1'b1;
    dot_std("b2b");
    check("b2b_opq_size", 64'(opq.size()), 64'd5);
    if (opq.size() == 5) begin
      check("b2b_op0", 64'(opq[0]), 64'h0D);
      check("b2b_op3", 64'(opq[3]), 64'h09);
    end
    mon_en = 1'b0;

    // Result held while out_ready is low; no pair accepted meanwhile
    bad = 0;
    @(negedge CLK);
    in_valid0 = 1'b1;
    in_a = 18'd9;
    in_b = 18'd9;
    repeat (10) begin
      @(negedge CLK);
      if (out_data0 !== 48'd170 || in_ready0 !== 1'b0 || out_valid0 !== 1'b1) bad++;
    end
    check("stall_hold", 64'(bad), 64'd0);
    in_valid0 = 1'b0;
    take(1'b0, "stall");

    // Two-cycle bubble between terms 2 and 3
    mon_en = 1'b1;
    cfg_bias = 48'd100;
    push(1'b0, 18'd1, 18'd5);
    push(1'b0, 18'd2, 18'd6);
    repeat (2) @(posedge CLK);
    push(1'b0, 18'd3, 18'd7);
    push(1'b0, 18'd4, 18'd8);
    wait_result(1'b0, "bub", 48'd170);
    n08 = 0;
    for (int i = 0; i + 1 < opq.size(); i++) if (opq[i] == 8'h08) n08++;
    check("bub_hold_cnt", 64'(n08), 64'd2);
    check("bub_opq_size", 64'(opq.size()), 64'd7);
    mon_en = 1'b0;
    take(1'b0, "bub");

    // LEN=1 with full-scale operands
    cfg_bias = 48'd0;
    push(1'b1, 18'h3FFFF, 18'h3FFFF);
    wait_result(1'b1, "len1", 48'h0000_FFFF_8000_1);
    take(1'b1, "len1");

    // Abort after 2 of 4 terms; clr coincides with a would-be handshake
    cfg_bias = 48'd100;
    push(1'b0, 18'd3, 18'd3);
    push(1'b0, 18'd4, 18'd4);
    @(negedge CLK);
    clr = 1'b1;
    in_valid0 = 1'b1;
    in_a = 18'd7;
    in_b = 18'd7;
    @(posedge CLK);
    #1;
    clr = 1'b0;
    in_valid0 = 1'b0;
    check("clr_opmode", 64'(dsp_opmode0), 64'h00);
    check("clr_dsp_a", 64'(dsp_a0), 64'd0);
    check("clr_out_valid", 64'(out_valid0), 64'd0);
    check("clr_in_ready", 64'(in_ready0), 64'd1);
    cfg_bias = 48'd0;
    for (int i = 0; i < 4; i++) push(1'b0, 18'd1, 18'd1);
    wait_result(1'b0, "postclr", 48'd4);
    take(1'b0, "postclr");

    // Asynchronous reset mid-accumulation
    cfg_bias = 48'd100;
    push(1'b0, 18'd1, 18'd5);
    push(1'b0, 18'd2, 18'd6);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_rel_rdy", 64'(in_ready0), 64'd1);
    dot_std("postrst");
    take(1'b0, "postrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
